// File: rtl/cam_pkg.sv
// Shared types and constants for the OV7670 capture path.
// CAPTURE_DECIM_EN selects a VGA sensor decimated 2:1 in each axis.
package cam_pkg;

   localparam int IMG_WIDTH_DEF  = 320;
   localparam int IMG_HEIGHT_DEF = 240;
   localparam int ADDR_W_DEF     = 17;
   localparam int FRAME_PIXELS   = IMG_WIDTH_DEF * IMG_HEIGHT_DEF;

   // RGB565 field positions within a 16-bit pixel
   localparam int RGB_R_HI = 15;
   localparam int RGB_R_LO = 11;
   localparam int RGB_G_HI = 10;
   localparam int RGB_G_LO = 5;
   localparam int RGB_B_HI = 4;
   localparam int RGB_B_LO = 0;

`ifdef CAPTURE_DECIM_EN
   localparam int DECIM_SHIFT = 1;
`else
   localparam int DECIM_SHIFT = 0;
`endif

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      BLANK  = 2'd1,
      ACTIVE = 2'd2
   } cap_state_t;

endpackage

// File: rtl/ov7670_capture_if.sv
// Camera byte bus in, raster write stream out. The capture block is the slave
// of the camera bus; the environment (sensor model + sink) is the master.
interface ov7670_capture_if #(
   parameter int ADDR_W = 17
) ();

   logic              vsync;
   logic              href;
   logic [7:0]        data;
   logic              we;
   logic [ADDR_W-1:0] wAddr;
   logic [15:0]       wData;
   logic              frame_done;
   logic              frame_err;

   modport master (
      output vsync, href, data,
      input  we, wAddr, wData, frame_done, frame_err
   );

   modport slave (
      input  vsync, href, data,
      output we, wAddr, wData, frame_done, frame_err
   );

endinterface

// File: rtl/cam_edge_det.sv
// One-flop edge detector: rise/fall pulses are combinational against the
// previous-cycle sample, so they line up with the cycle the new level arrives.
module cam_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic i_sig,
   output logic o_rise,
   output logic o_fall
);

   logic r_sig_d;

   // NOTE: non-blocking so the flop captures the pre-edge value of i_sig.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_sig_d <= 1'b0;
      else        r_sig_d <= i_sig;
   end

   assign o_rise = i_sig & ~r_sig_d;
   assign o_fall = ~i_sig & r_sig_d;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 byte-serial RGB565 capture into a raster write stream (we/wAddr/wData).
// CAPTURE_DECIM_EN: VGA source, only even-row/even-col pixels are written.
module ov7670_capture
   import cam_pkg::*;
#(
   parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
   parameter int ADDR_W     = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   ov7670_capture_if.slave   cam
);

   localparam int DEC       = DECIM_SHIFT;
   localparam int SRC_W     = IMG_WIDTH  << DEC;
   localparam int SRC_H     = IMG_HEIGHT << DEC;
   localparam int COL_W     = $clog2(SRC_W);
   localparam int ROW_W     = $clog2(SRC_H + 1);
   localparam int CNT_W     = ADDR_W + 1;
   localparam int FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(SRC_W - 1);
   localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(SRC_H);
   localparam logic [CNT_W-1:0] ADDR_END = CNT_W'(FRAME_PIX);

   cap_state_t        r_state;
   cap_state_t        w_state_nxt;
   logic              r_phase;
   logic [7:0]        r_hi;
   logic [COL_W-1:0]  r_col;
   logic [ROW_W-1:0]  r_row;
   logic [CNT_W-1:0]  r_addr;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [15:0]       r_wdata;
   logic              r_frame_done;
   logic              r_frame_err;

   logic              w_vs_rise;
   logic              w_vs_fall;
   logic              w_href_rise;
   logic              w_href_fall;
   logic              w_keep;
   logic              w_overflow;
   logic [ROW_W-1:0]  w_next_row;
   logic [CNT_W-1:0]  w_realign_addr;

   cam_edge_det u_vsync_edge (
      .clk    (clk),
      .reset  (reset),
      .i_sig  (cam.vsync),
      .o_rise (w_vs_rise),
      .o_fall (w_vs_fall)
   );

   cam_edge_det u_href_edge (
      .clk    (clk),
      .reset  (reset),
      .i_sig  (cam.href),
      .o_rise (w_href_rise),
      .o_fall (w_href_fall)
   );

`ifdef CAPTURE_DECIM_EN
   assign w_keep = ~r_col[0] & ~r_row[0];
`else
   assign w_keep = 1'b1;
`endif

   assign w_overflow = (r_row == ROW_END);

   // Realigned start address of the next line that will actually be written
   always_comb begin
      w_next_row = r_row + 1'b1;
      if (w_next_row >= ROW_END) w_realign_addr = ADDR_END;
      else w_realign_addr = CNT_W'((int'(w_next_row) + DEC) >> DEC) * CNT_W'(IMG_WIDTH);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= SYNC;
      else        r_state <= w_state_nxt;
   end

   // NOTE: next state defaults to the current one first, so no path infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SYNC:    if (w_vs_rise) w_state_nxt = BLANK;
         BLANK:   if (w_vs_fall) w_state_nxt = ACTIVE;
         ACTIVE:  if (w_vs_rise) w_state_nxt = BLANK;
         default: w_state_nxt = SYNC;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_phase      <= 1'b0;
         r_hi         <= '0;
         r_col        <= '0;
         r_row        <= '0;
         r_addr       <= '0;
         r_we         <= 1'b0;
         r_waddr      <= '0;
         r_wdata      <= '0;
         r_frame_done <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_we         <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            BLANK: begin
               r_phase <= 1'b0;
               r_col   <= '0;
               r_row   <= '0;
               r_addr  <= '0;
               // error flag stays readable through blanking, cleared as capture starts
               if (w_vs_fall) r_frame_err <= 1'b0;
            end
            ACTIVE: begin
               if (w_vs_rise) begin
                  r_frame_done <= 1'b1;
                  if (!w_overflow) r_frame_err <= 1'b1;
               end else if (cam.href) begin
                  r_phase <= ~r_phase;
                  if (!r_phase) begin
                     r_hi <= cam.data;
                  end else if (w_overflow) begin
                     r_frame_err <= 1'b1;
                  end else begin
                     if (w_keep) begin
                        r_we    <= 1'b1;
                        r_waddr <= r_addr[ADDR_W-1:0];
                        r_wdata <= {r_hi, cam.data};
                        r_addr  <= r_addr + 1'b1;
                     end
                     if (r_col == COL_LAST) begin
                        r_col <= '0;
                        r_row <= w_next_row;
                     end else begin
                        r_col <= r_col + 1'b1;
                     end
                  end
               end else if (w_href_fall) begin
                  r_phase <= 1'b0;
                  if (r_phase) r_frame_err <= 1'b1;
                  if (r_col != '0) begin
                     r_frame_err <= 1'b1;
                     r_col       <= '0;
                     r_row       <= w_next_row;
                     r_addr      <= w_realign_addr;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign cam.we         = r_we;
   assign cam.wAddr      = r_waddr;
   assign cam.wData      = r_wdata;
   assign cam.frame_done = r_frame_done;
   assign cam.frame_err  = r_frame_err;

   // href rise carries no action: the byte phase is already zero after every line end
   logic w_unused;
   assign w_unused = w_href_rise;

endmodule

// File: tb/tb_ov7670_capture.sv
// Table-driven bench for ov7670_capture on a reduced 8x4 image; frame-level
// vectors plus hand sequences for mid-frame start and asynchronous reset.
module tb_ov7670_capture;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int AW = 5;
`ifdef CAPTURE_DECIM_EN
   localparam int DEC = 1;
`else
   localparam int DEC = 0;
`endif
   localparam int SW = W << DEC;
   localparam int SH = H << DEC;

   typedef struct {
      string name;
      int    lines;
      int    bad_line;
      int    bad_bytes;
      int    exp_writes;
      logic  exp_err;
   } vec_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ov7670_capture_if #(.ADDR_W(AW)) ifc ();

   ov7670_capture #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .ADDR_W     (AW)
   ) dut (
      .clk   (clk),
      .reset (rst_n),
      .cam   (ifc)
   );

   int            n_total = 0;
   int            n_pass  = 0;
   wr_t           q_exp[$];
   logic [AW-1:0] q_log_addr[$];
   logic [15:0]   q_log_data[$];
   bit            expect_none = 1'b0;
   logic          prev_we     = 1'b0;
   int            done_cnt    = 0;
   logic          err_at_done = 1'b0;
   int            m_row, m_col, pix_n, frame_base;
   vec_t          vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference: expected address is row/col geometry, not a running counter
   task automatic model_pixel(input logic [15:0] v);
      wr_t e;
      if (m_row < SH) begin
         if (DEC == 0 || (m_row % 2 == 0 && m_col % 2 == 0)) begin
            e.addr = AW'((m_row >> DEC) * W + (m_col >> DEC));
            e.data = v;
            q_exp.push_back(e);
         end
         m_col++;
         if (m_col == SW) begin
            m_col = 0;
            m_row++;
         end
      end
   endtask

   task automatic drive_bytes(input int n, input bit model_on);
      logic [15:0] v;
      for (int b = 0; b < n; b++) begin
         cyc();
         ifc.href = 1'b1;
         v = 16'(frame_base + pix_n);
         if (b % 2 == 0) begin
            ifc.data = v[15:8];
         end else begin
            ifc.data = v[7:0];
            if (model_on) model_pixel(v);
            pix_n++;
         end
      end
   endtask

   task automatic drive_line(input int n, input bit model_on);
      drive_bytes(n, model_on);
      cyc();
      ifc.href = 1'b0;
      ifc.data = 8'h00;
      cyc();
      cyc();
      if (model_on && m_col != 0) begin
         m_col = 0;
         if (m_row < SH) m_row++;
      end
   endtask

   task automatic prime_vsync();
      cyc();
      ifc.vsync = 1'b1;
      repeat (3) cyc();
   endtask

   task automatic run_frame(input vec_t v, input int idx);
      int d0;
      cyc();
      ifc.vsync  = 1'b0;
      m_row      = 0;
      m_col      = 0;
      pix_n      = 0;
      frame_base = idx * 1000 + 256;
      q_log_addr.delete();
      q_log_data.delete();
      cyc();
      cyc();
      for (int l = 0; l < v.lines; l++)
         drive_line((l == v.bad_line) ? v.bad_bytes : 2 * SW, 1'b1);
      d0 = done_cnt;
      cyc();
      ifc.vsync = 1'b1;
      repeat (4) cyc();
      check({v.name, "_done_pulses"}, done_cnt - d0, 1);
      check({v.name, "_err_at_done"}, err_at_done, v.exp_err);
      check({v.name, "_write_count"}, q_log_addr.size(), v.exp_writes);
      check({v.name, "_missing_writes"}, q_exp.size(), 0);
      check({v.name, "_err_in_blank"}, ifc.frame_err, v.exp_err);
      if (q_log_addr.size() > 0) check({v.name, "_first_addr"}, q_log_addr[0], 0);
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (rst_n) begin
         if (ifc.frame_done) begin
            done_cnt++;
            err_at_done = ifc.frame_err;
         end
         if (ifc.we) begin
            check("we_back_to_back", prev_we, 0);
            q_log_addr.push_back(ifc.wAddr);
            q_log_data.push_back(ifc.wData);
            if (expect_none) begin
               check("write_before_sync", ifc.we, 0);
            end else if (q_exp.size() == 0) begin
               check("unexpected_write", ifc.we, 0);
            end else begin
               e = q_exp.pop_front();
               check("wAddr", ifc.wAddr, e.addr);
               check("wData", ifc.wData, e.data);
            end
         end
         prev_we = ifc.we;
      end
   end

   initial begin
      vecs[0] = '{"clean",       SH,               -1, 0,          32,                        1'b0};
      vecs[1] = '{"odd_line",    SH,                1, 2 * SW + 1, 32,                        1'b1};
      vecs[2] = '{"short_line",  SH,                2, 2 * SW - 4, 32 - (2 >> DEC),           1'b1};
      vecs[3] = '{"overflow",    SH + 1,           -1, 0,          32,                        1'b1};
      vecs[4] = '{"short_frame", SH - (1 << DEC),  -1, 0,          24,                        1'b1};
      vecs[5] = '{"recover",     SH,               -1, 0,          32,                        1'b0};
      vecs[6] = '{"long_line",   SH,                0, 2 * SW + 4, (DEC != 0) ? 32 : 26,      1'b1};
      vecs[7] = '{"clean2",      SH,               -1, 0,          32,                        1'b0};

      rst_n     = 1'b0;
      ifc.vsync = 1'b0;
      ifc.href  = 1'b0;
      ifc.data  = 8'h00;
      frame_base = 0;
      pix_n      = 0;
      #12;
      check("rst_we",         ifc.we, 0);
      check("rst_wAddr",      ifc.wAddr, 0);
      check("rst_wData",      ifc.wData, 0);
      check("rst_frame_done", ifc.frame_done, 0);
      check("rst_frame_err",  ifc.frame_err, 0);
      cyc();
      rst_n = 1'b1;

      // Stimulus already mid-frame, no vsync seen yet
      expect_none = 1'b1;
      drive_line(2 * SW, 1'b0);
      drive_line(2 * SW, 1'b0);
      check("midframe_no_writes", q_log_addr.size(), 0);
      expect_none = 1'b0;

      prime_vsync();
      for (int i = 0; i < 8; i++) begin
         run_frame(vecs[i], i);
         if (i == 0 && q_log_data.size() > 1)
            check("pixel1_source", q_log_data[1], 16'(frame_base + (1 << DEC)));
         if (i == 1 && q_log_addr.size() > ((2 >> DEC) * W))
            check("odd_line_realign", q_log_addr[(2 >> DEC) * W], (2 >> DEC) * W);
         if (i == 3 && q_log_addr.size() > 0)
            check("overflow_last_addr", q_log_addr[q_log_addr.size() - 1], W * H - 1);
      end

      // Asynchronous reset in the middle of a frame carrying an error
      cyc();
      ifc.vsync  = 1'b0;
      m_row      = 0;
      m_col      = 0;
      pix_n      = 0;
      frame_base = 9000;
      cyc();
      drive_line(2 * SW + 1, 1'b1);
      drive_bytes(6, 1'b1);
      check("pre_reset_err", ifc.frame_err, 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_we",         ifc.we, 0);
      check("async_rst_wAddr",      ifc.wAddr, 0);
      check("async_rst_wData",      ifc.wData, 0);
      check("async_rst_frame_done", ifc.frame_done, 0);
      check("async_rst_frame_err",  ifc.frame_err, 0);
      q_exp.delete();
      cyc();
      ifc.href = 1'b0;
      cyc();
      rst_n = 1'b1;

      expect_none = 1'b1;
      q_log_addr.delete();
      q_log_data.delete();
      drive_line(2 * SW, 1'b0);
      drive_line(2 * SW, 1'b0);
      check("post_reset_no_writes", q_log_addr.size(), 0);
      expect_none = 1'b0;
      prime_vsync();
      run_frame(vecs[0], 8);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
